jtag_dr_tx: RTL

JTAG_DR_TX -- requirements
Module: jtag_dr_tx

---
 rtl/jtag_dr_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/jtag_dr_tx.sv
// SoC-to-host data register for the JTAGG ER1/ER2 chain: ER1 reads the next held word, ER2 reads status.
// Define JTAG_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-word FIFO.
module jtag_dr_tx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_done,
  input  logic        jtck,
  input  logic        jshift,
  input  logic        jupdate,
  input  logic        jce1,
  input  logic        jce2,
  input  logic        jrstn,
  output logic        jtdo1,
  output logic        jtdo2
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef JTAG_TX_FIFO_EN
  localparam int unsigned CAP = FIFO_DEPTH;
`else
  localparam int unsigned CAP = 1;
`endif

  logic [3:0]       tap;
  logic             tck_rise;
  logic             shift_q;
  logic             sel;
  logic             cap_valid;
  logic             underrun;
  logic             jtdo_q;
  logic [31:0]      sreg;
  logic [31:0]      head;
  logic [31:0]      status;
  logic [5:0]       bitcnt;
  logic [CNT_W-1:0] count;
  logic [31:0]      cnt32;
  logic [2:0]       occ;
  logic             full;
  logic             push;
  logic             pop;
  logic             capture;

  assign tck_rise = ~tap[3] & tap[2];
  assign full     = (count == CNT_W'(CAP));
  assign tx_ready = ~full;
  assign push     = tx_valid & ~full;
  assign capture  = tck_rise & (jce1 | jce2) & ~jshift;
  assign pop      = jrstn & tck_rise & jupdate & ~sel & cap_valid & (bitcnt == 6'd32);

  // Occupancy is a 3-bit field, so deeper stores report 7.
  assign cnt32  = 32'(count);
  assign occ    = (cnt32 > 32'd7) ? 3'd7 : cnt32[2:0];
  assign status = {27'd0, occ, underrun, (count != '0)};

  assign jtdo1 = jtdo_q;
  assign jtdo2 = jtdo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap <= '0;
    end else begin
      tap <= {tap[2:0], jtck};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= 1'b0;
      sreg      <= '0;
      bitcnt    <= '0;
      cap_valid <= 1'b0;
      underrun  <= 1'b0;
      shift_q   <= 1'b0;
    end else if (!jrstn) begin
      sel       <= 1'b0;
      sreg      <= '0;
      bitcnt    <= '0;
      cap_valid <= 1'b0;
      shift_q   <= 1'b0;
    end else if (tck_rise) begin
      shift_q <= jshift;
      if (capture) begin
        sel    <= jce2;
        bitcnt <= '0;
        if (jce2) begin
          sreg     <= status;
          underrun <= 1'b0;
        end else if (count != '0) begin
          sreg      <= head;
          cap_valid <= 1'b1;
        end else begin
          sreg      <= '0;
          cap_valid <= 1'b0;
          underrun  <= 1'b1;
        end
      end else if (shift_q) begin
        sreg <= {1'b0, sreg[31:1]};
        if (bitcnt != 6'd32) begin
          bitcnt <= bitcnt + 6'd1;
        end
      end
      if (pop) begin
        cap_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jtdo_q  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      jtdo_q  <= sreg[0];
      tx_done <= pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

`ifdef JTAG_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];
`else
  logic [31:0] hold_data;

  always_ff @(posedge clk) begin
    if (push) begin
      hold_data <= tx_data;
    end
  end

  assign head = hold_data;
`endif

endmodule
